// File: rtl/datamemory_dumper_pkg.sv
// Shared types and constants for the data-memory dumper.
// State encoding, byte-count helper, UART byte width.
package datamemory_dumper_pkg;

  // Shared with the UART transmitter.
  localparam int UART_NBITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    SEND,
    WAIT_TX,
    NEXT,
    DONE
  } state_e;

  // Bytes needed to carry a d-bit word over a t-bit link.
  function automatic int nbytes(input int d, input int t);
    return (d + t - 1) / t;
  endfunction

endpackage

// File: rtl/datamemory_dumper.sv
// Walks data memory 0..CELDAS-1 and streams every word to the UART
// low byte first. Read side only: i_OutData in, o_Rd/o_Addr out.
// Ports: i_clock/i_reset (sync, active high), i_start, o_Rd, o_Addr,
//   i_OutData, o_tx_data, o_tx_start, i_tx_done, o_busy, o_done.
module datamemory_dumper
  import datamemory_dumper_pkg::*;
#(
  parameter int NBITS_O  = 11,
  parameter int NBITS_D  = 16,
  parameter int CELDAS   = 10,
  parameter int NBITS_TX = UART_NBITS
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  output logic                o_Rd,
  output logic [NBITS_O-1:0]  o_Addr,
  input  logic [NBITS_D-1:0]  i_OutData,
  output logic [NBITS_TX-1:0] o_tx_data,
  output logic                o_tx_start,
  input  logic                i_tx_done,
  output logic                o_busy,
  output logic                o_done
);

  localparam int NBYTES = nbytes(NBITS_D, NBITS_TX);
  localparam int BIW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int WEXT   = NBYTES * NBITS_TX;

  localparam logic [BIW-1:0]     LAST_B = BIW'(NBYTES - 1);
  localparam logic [NBITS_O-1:0] LAST_A = NBITS_O'(CELDAS - 1);

  state_e              state_q;
  logic [NBITS_O-1:0]  addr_q;
  logic [NBITS_D-1:0]  word_q;
  logic [BIW-1:0]      byte_q;
  logic                rd_q;
  logic [NBITS_O-1:0]  oaddr_q;
  logic [NBITS_TX-1:0] txd_q;
  logic                txs_q;
  logic                busy_q;
  logic                done_q;

  logic [BIW-1:0]      byte_d;
  logic [NBITS_O-1:0]  addr_d;

  assign byte_d = byte_q + 1'b1;
  assign addr_d = addr_q + 1'b1;

  // Zero-extend the word, then pick byte i.
  function automatic logic [NBITS_TX-1:0] sel_byte(
    input logic [NBITS_D-1:0] w,
    input logic [BIW-1:0]     i
  );
    logic [WEXT-1:0] e;
    e = WEXT'(w);
    return e[int'(i) * NBITS_TX +: NBITS_TX];
  endfunction

  // Outputs are loaded with the value of the state being entered,
  // so they line up with state_q without any combinational decode.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      byte_q  <= '0;
      rd_q    <= 1'b0;
      oaddr_q <= '0;
      txd_q   <= '0;
      txs_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      txs_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            addr_q  <= '0;
            oaddr_q <= '0;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= READ;
          end
        end
        READ: begin
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          word_q  <= i_OutData;
          byte_q  <= '0;
          txd_q   <= sel_byte(i_OutData, '0);
          txs_q   <= 1'b1;
          rd_q    <= 1'b0;
          state_q <= SEND;
        end
        SEND: begin
          state_q <= WAIT_TX;
        end
        WAIT_TX: begin
          if (i_tx_done) begin
            if (byte_q == LAST_B) begin
              state_q <= NEXT;
            end else begin
              byte_q  <= byte_d;
              txd_q   <= sel_byte(word_q, byte_d);
              txs_q   <= 1'b1;
              state_q <= SEND;
            end
          end
        end
        NEXT: begin
          if (addr_q == LAST_A) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            addr_q  <= addr_d;
            oaddr_q <= addr_d;
            rd_q    <= 1'b1;
            state_q <= READ;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          rd_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_Rd       = rd_q;
  assign o_Addr     = oaddr_q;
  assign o_tx_data  = txd_q;
  assign o_tx_start = txs_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_datamemory_dumper.sv
// Randomized bench for datamemory_dumper against a byte-stream model.
// Default instance plus a NBITS_D=12 / CELDAS=1 variant.
module tb_datamemory_dumper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic        rd;
  logic [10:0] addr;
  logic [15:0] rdata;
  logic [7:0]  txd;
  logic        txs, txdone, busy, done;

  logic        start2;
  logic        rd2;
  logic [10:0] addr2;
  logic [11:0] rdata2;
  logic [7:0]  txd2;
  logic        txs2, txdone2, busy2, done2;

  logic [15:0] mem [10];
  logic [11:0] mem2;

  always_comb rdata  = (addr < 11'd10) ? mem[addr[3:0]] : 16'hDEAD;
  always_comb rdata2 = (addr2 == 11'd0) ? mem2 : 12'hFFF;

  datamemory_dumper u_dut (
    .i_clock(clk), .i_reset(rst), .i_start(start),
    .o_Rd(rd), .o_Addr(addr), .i_OutData(rdata),
    .o_tx_data(txd), .o_tx_start(txs), .i_tx_done(txdone),
    .o_busy(busy), .o_done(done)
  );

  datamemory_dumper #(.NBITS_D(12), .CELDAS(1)) u_dut2 (
    .i_clock(clk), .i_reset(rst), .i_start(start2),
    .o_Rd(rd2), .o_Addr(addr2), .i_OutData(rdata2),
    .o_tx_data(txd2), .o_tx_start(txs2), .i_tx_done(txdone2),
    .o_busy(busy2), .o_done(done2)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // TX model: W wait cycles per byte, optional stall and noise.
  int  cnt = 0, wmax = 1, stall_at = -1, stall_len = 0, start_n = 0;
  bit  spur = 0, in_wait = 0;
  int  wq[$];

  always @(posedge clk) begin
    int w;
    #1;
    if (!busy) begin
      cnt = 0;
      in_wait = 0;
    end
    if (txs) begin
      w = (start_n == stall_at) ? stall_len : int'($urandom_range(1, wmax));
      wq.push_back(w);
      start_n++;
      cnt = w;
      in_wait = 0;
      txdone = spur && ($urandom_range(0, 1) == 1);
    end else if (cnt > 0) begin
      in_wait = 1;
      cnt--;
      txdone = (cnt == 0);
    end else begin
      in_wait = 0;
      txdone = spur && ($urandom_range(0, 7) == 0);
    end
  end

  // Observation of the default instance.
  logic [7:0] obs[$];
  logic [7:0] last_b = '0;
  int done_cnt = 0, busy_cyc = 0, hold_err = 0;
  int rd_cnt [10];

  always @(negedge clk) begin
    if (txs) begin
      obs.push_back(txd);
      last_b = txd;
    end
    if (in_wait && txd !== last_b) hold_err++;
    if (done) done_cnt++;
    if (busy) busy_cyc++;
    if (rd && addr < 11'd10) rd_cnt[addr[3:0]]++;
  end

  // Variant: done one cycle after each start.
  bit f2 = 0;
  logic [7:0] q2[$];
  int done2_cnt = 0;

  always @(posedge clk) begin
    #1;
    txdone2 = f2;
    f2 = txs2;
  end

  always @(negedge clk) begin
    if (txs2) q2.push_back(txd2);
    if (done2) done2_cnt++;
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic run_dump(input int restart_at);
    int k, e, exp_busy;
    obs.delete();
    wq.delete();
    start_n  = 0;
    done_cnt = 0;
    busy_cyc = 0;
    hold_err = 0;
    foreach (rd_cnt[i]) rd_cnt[i] = 0;
    pulse_start();
    k = 0;
    while (done_cnt == 0 && k < 20000) begin
      start = (k == restart_at);
      @(posedge clk); #1;
      k++;
    end
    start = 0;
    check("busy_fall", busy, 0);
    check("nbytes", obs.size(), 20);
    for (int a = 0; a < 10; a++)
      for (int b = 0; b < 2; b++) begin
        e = (int'(mem[a]) >> (8 * b)) & 'hFF;
        if (a * 2 + b < obs.size())
          check($sformatf("byte_a%0d_b%0d", a, b), obs[a * 2 + b], e);
      end
    for (int a = 0; a < 10; a++)
      check($sformatf("rd_cycles_a%0d", a), rd_cnt[a], 2);
    exp_busy = 1 + 10 * 3;
    foreach (wq[i]) exp_busy += 1 + wq[i];
    check("busy_cycles", busy_cyc, exp_busy);
    check("tx_hold", hold_err, 0);
    repeat (3) @(posedge clk);
    #1;
    check("done_count", done_cnt, 1);
  endtask

  task automatic run_dut2(input logic [11:0] v);
    int k;
    mem2 = v;
    q2.delete();
    done2_cnt = 0;
    @(posedge clk); #1 start2 = 1;
    @(posedge clk); #1 start2 = 0;
    k = 0;
    while (done2_cnt == 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("v_busy_fall", busy2, 0);
    check("v_nbytes", q2.size(), 2);
    if (q2.size() >= 2) begin
      check("v_byte0", q2[0], int'(v) & 'hFF);
      check("v_byte1", q2[1], (int'(v) >> 8) & 'hFF);
    end
    repeat (3) @(posedge clk);
    #1;
    check("v_done_count", done2_cnt, 1);
  endtask

  initial begin
    int k;
    rst = 1; start = 0; start2 = 0;
    txdone = 0; txdone2 = 0; mem2 = '0;
    foreach (mem[i]) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd", rd, 0);
    check("rst_addr", addr, 0);
    check("rst_txd", txd, 0);
    check("rst_txs", txs, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_v_txd", txd2, 0);
    check("rst_v_busy", busy2, 0);
    rst = 0;

    // Incrementing pattern, single-cycle TX.
    foreach (mem[i]) mem[i] = 16'(i);
    run_dump(-1);

    // Fixed cell 3, stall on byte 5, restart attempt and noise.
    foreach (mem[i]) mem[i] = 16'($urandom);
    mem[3] = 16'hA5C3;
    wmax = 1; stall_at = 5; stall_len = 50; spur = 1;
    run_dump(30);

    // Random contents and TX latency.
    stall_at = -1; wmax = 4;
    for (int r = 0; r < 3; r++) begin
      foreach (mem[i]) mem[i] = 16'($urandom);
      run_dump(int'($urandom_range(5, 60)));
    end

    // Abort during WAIT_TX of word 4.
    spur = 0; wmax = 3; stall_at = 8; stall_len = 20;
    obs.delete(); wq.delete();
    start_n = 0; done_cnt = 0;
    pulse_start();
    k = 0;
    while (start_n < 9 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    check("abort_rd", rd, 0);
    check("abort_addr", addr, 0);
    check("abort_txd", txd, 0);
    check("abort_txs", txs, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    rst = 0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_idle", busy, 0);

    stall_at = -1; wmax = 2; spur = 1;
    foreach (mem[i]) mem[i] = 16'($urandom);
    run_dump(-1);

    // 12-bit, single-cell variant.
    run_dut2(12'hABC);
    run_dut2(12'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
